// File: rtl/input_loader_pkg.sv
// Shared widths, read-index layout and FSM encoding for the X/A operand loader.
package input_loader_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Buffer index: column in the upper bits, row in the lower bits
  typedef struct packed {
    logic [1:0] col;
    logic [2:0] row;
  } idx_t;
endpackage

// File: rtl/input_loader_if.sv
// Controller-facing bundle of the loader: load window, X stream, ROM port, operand reads.
interface input_loader_if #(
  parameter int unsigned DATA_W = input_loader_pkg::DATA_W
);
  logic              input_load_en;
  logic [DATA_W-1:0] x_in;
  logic              x_valid;
  logic              rom_en;
  logic [4:0]        rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              xload_done;
  logic              aload_done;
  logic [4:0]        a_cnt;
  logic [2:0]        rd_row;
  logic [1:0]        rd_col;
  logic [DATA_W-1:0] x_rd;
  logic [DATA_W-1:0] a_rd;

  modport master (
    output input_load_en, x_in, x_valid, rom_data, rd_row, rd_col,
    input  rom_en, rom_addr, xload_done, aload_done, a_cnt, x_rd, a_rd
  );

  modport slave (
    input  input_load_en, x_in, x_valid, rom_data, rd_row, rd_col,
    output rom_en, rom_addr, xload_done, aload_done, a_cnt, x_rd, a_rd
  );
endinterface

// File: rtl/input_loader_reg_bank.sv
// DEPTH x DATA_W register bank: one write port, one registered read port.
module reg_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; contents survive a reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end
endmodule

// File: rtl/input_loader.sv
// Loads 32 serial X elements and 32 ROM coefficients into two operand banks,
// and serves registered operand reads to the controller.
module input_loader #(
  parameter int unsigned DATA_W = input_loader_pkg::DATA_W,
  parameter int unsigned DEPTH  = input_loader_pkg::DEPTH
) (
  input logic           clk,
  input logic           rst,
  input_loader_if.slave bus
);
  import input_loader_pkg::state_t;
  import input_loader_pkg::ST_IDLE;
  import input_loader_pkg::ST_LOAD;
  import input_loader_pkg::ST_DONE;
  import input_loader_pkg::IDX_W;
  import input_loader_pkg::CNT_W;
  import input_loader_pkg::idx_t;

  state_t           state;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] a_req;
  logic             a_pend;
  logic [IDX_W-1:0] a_waddr;
  logic             rom_en;
  logic [IDX_W-1:0] rom_addr;
  logic [IDX_W-1:0] a_cnt;
  logic             xload_done;
  logic             aload_done;
  logic             load_go_c;
  logic             x_we_c;
  logic             a_we_c;
  idx_t             rd_idx_c;

  // Writes only happen inside an uninterrupted load window
  always_comb begin
    load_go_c = (state == ST_LOAD) && bus.input_load_en;
    x_we_c    = load_go_c && bus.x_valid && (x_cnt < CNT_W'(DEPTH));
    a_we_c    = load_go_c && a_pend;
    rd_idx_c  = '{col: bus.rd_col, row: bus.rd_row};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      x_cnt      <= '0;
      a_req      <= '0;
      a_pend     <= 1'b0;
      a_waddr    <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      a_cnt      <= '0;
      xload_done <= 1'b0;
      aload_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          a_pend <= 1'b0;
          rom_en <= 1'b0;
          if (bus.input_load_en) begin
            // First ROM request goes out on the entry edge
            state      <= ST_LOAD;
            x_cnt      <= '0;
            a_req      <= CNT_W'(1);
            rom_en     <= 1'b1;
            rom_addr   <= '0;
            a_cnt      <= '0;
            xload_done <= 1'b0;
            aload_done <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!bus.input_load_en) begin
            state  <= ST_IDLE;
            rom_en <= 1'b0;
            a_pend <= 1'b0;
          end else begin
            if (x_we_c) begin
              x_cnt <= x_cnt + CNT_W'(1);
              if (x_cnt == CNT_W'(DEPTH - 1)) xload_done <= 1'b1;
            end
            a_pend  <= rom_en;
            a_waddr <= rom_addr;
            if (a_req < CNT_W'(DEPTH)) begin
              rom_en   <= 1'b1;
              rom_addr <= a_req[IDX_W-1:0];
              a_req    <= a_req + CNT_W'(1);
            end else begin
              rom_en <= 1'b0;
            end
            if (a_we_c) begin
              if (a_cnt == IDX_W'(DEPTH - 1)) aload_done <= 1'b1;
              else                            a_cnt <= a_cnt + IDX_W'(1);
            end
            if (xload_done && aload_done) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          rom_en <= 1'b0;
          a_pend <= 1'b0;
          if (!bus.input_load_en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IDX_W)) u_x_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (x_we_c),
    .waddr (x_cnt[IDX_W-1:0]),
    .wdata (bus.x_in),
    .raddr (IDX_W'(rd_idx_c)),
    .rdata (bus.x_rd)
  );

  reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IDX_W)) u_a_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (a_we_c),
    .waddr (a_waddr),
    .wdata (bus.rom_data),
    .raddr (IDX_W'(rd_idx_c)),
    .rdata (bus.a_rd)
  );

  assign bus.rom_en     = rom_en;
  assign bus.rom_addr   = rom_addr;
  assign bus.a_cnt      = a_cnt;
  assign bus.xload_done = xload_done;
  assign bus.aload_done = aload_done;
endmodule

// File: tb/tb_input_loader.sv
// Self-checking bench for input_loader: cycle-level model of counters, flags and buffers.
module tb_input_loader;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [DW-1:0] rom_mem [32];
  logic [DW-1:0] xm [32];
  logic [DW-1:0] am [32];
  bit            xk [32];
  bit            ak [32];

  input_loader_if #(.DATA_W(DW)) bus ();

  input_loader #(.DATA_W(DW), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: data appears the cycle after a strobe; garbage otherwise
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_mem[bus.rom_addr];
    else            bus.rom_data <= DW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int i);
    bus.rd_col = 2'(i >> 3);
    bus.rd_row = 3'(i & 7);
  endtask

  task automatic fill_rom(input bit ramp);
    for (int i = 0; i < 32; i++) rom_mem[i] = ramp ? DW'(2 * i) : DW'($urandom);
  endtask

  // mode: 0 x_valid always, 1 alternating, 2 random
  task automatic do_load(input int mode, input bit fixed, input int abort_at, input int rst_at);
    int xw, aw, idx, done_e, e;
    logic [DW-1:0] ex_x, ex_a;
    bit kx, ka, exp_en, fin, ab;
    int exp_addr;
    xw = 0; aw = 0; done_e = -1; fin = 0;
    @(negedge clk);
    bus.input_load_en = 1'b1;
    bus.x_valid = 1'b0;
    idx = $urandom_range(0, 31);
    set_rd(idx);
    ex_x = xm[idx]; kx = xk[idx]; ex_a = am[idx]; ka = ak[idx];
    exp_en = 1'b1; exp_addr = 0;
    for (e = 0; e < 200 && !fin; e++) begin
      @(negedge clk);
      chk("rom_en", 32'(bus.rom_en), 32'(exp_en));
      if (exp_en) chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
      chk("a_cnt", 32'(bus.a_cnt), 32'(aw > 31 ? 31 : aw));
      chk("aload_done", 32'(bus.aload_done), 32'(aw == 32));
      chk("xload_done", 32'(bus.xload_done), 32'(xw == 32));
      if (kx) chk("x_rd_load", 32'(bus.x_rd), 32'(ex_x));
      if (ka) chk("a_rd_load", 32'(bus.a_rd), 32'(ex_a));
      if (abort_at >= 0 && e == abort_at + 1) begin
        fin = 1;
      end else if (rst_at >= 0 && e == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_rom_en", 32'(bus.rom_en), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_a_cnt", 32'(bus.a_cnt), 0);
        chk("rst_xdone", 32'(bus.xload_done), 0);
        chk("rst_adone", 32'(bus.aload_done), 0);
        chk("rst_x_rd", 32'(bus.x_rd), 0);
        chk("rst_a_rd", 32'(bus.a_rd), 0);
        bus.input_load_en = 1'b0;
        bus.x_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rom_en", 32'(bus.rom_en), 0);
        fin = 1;
      end else if (done_e >= 0 && e >= done_e + 2) begin
        fin = 1;
      end else begin
        ab = (abort_at >= 0 && e == abort_at);
        if (ab) bus.input_load_en = 1'b0;
        bus.x_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((e % 2) == 0) : 1'($urandom_range(0, 1));
        bus.x_in = fixed ? DW'(xw + 1) : DW'($urandom);
        idx = $urandom_range(0, 31);
        set_rd(idx);
        ex_x = xm[idx]; kx = xk[idx]; ex_a = am[idx]; ka = ak[idx];
        if (ab) begin
          exp_en = 1'b0;
        end else begin
          if (bus.x_valid && xw < 32) begin
            xm[xw] = bus.x_in; xk[xw] = 1; xw++;
          end
          if (e >= 1 && e <= 32) begin
            am[e-1] = rom_mem[e-1]; ak[e-1] = 1; aw++;
          end
          exp_en = (e + 1) <= 31;
          exp_addr = e + 1;
          if (xw == 32 && aw == 32 && done_e < 0) done_e = e + 1;
        end
      end
    end
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL load_timeout observed=running expected=finished");
    end
  endtask

  // Leave DONE, confirm flags hold in IDLE
  task automatic finish_load();
    bus.input_load_en = 1'b0;
    @(negedge clk);
    chk("hold_xdone", 32'(bus.xload_done), 1);
    chk("hold_adone", 32'(bus.aload_done), 1);
    chk("hold_a_cnt", 32'(bus.a_cnt), 31);
    chk("idle_rom_en", 32'(bus.rom_en), 0);
  endtask

  task automatic readback();
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i > 0 && xk[i-1]) chk("x_rd", 32'(bus.x_rd), 32'(xm[i-1]));
      if (i > 0 && ak[i-1]) chk("a_rd", 32'(bus.a_rd), 32'(am[i-1]));
      if (i < 32) set_rd(i);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 32; i++) begin xk[i] = 0; ak[i] = 0; xm[i] = '0; am[i] = '0; end
    rst = 1'b1;
    bus.input_load_en = 1'b0;
    bus.x_in = '0;
    bus.x_valid = 1'b0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    fill_rom(1'b1);
    #2 rst = 1'b0;
    #1;
    chk("reset_rom_en", 32'(bus.rom_en), 0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 0);
    chk("reset_a_cnt", 32'(bus.a_cnt), 0);
    chk("reset_xdone", 32'(bus.xload_done), 0);
    chk("reset_adone", 32'(bus.aload_done), 0);
    chk("reset_x_rd", 32'(bus.x_rd), 0);
    chk("reset_a_rd", 32'(bus.a_rd), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Ramp load: x = k+1, ROM = 2*addr
    do_load(0, 1'b1, -1, -1);
    finish_load();
    readback();
    @(negedge clk);
    set_rd(21);
    @(negedge clk);
    chk("ramp_x_rd_c2r5", 32'(bus.x_rd), 22);
    chk("ramp_a_rd_c2r5", 32'(bus.a_rd), 42);

    // Alternating x_valid, random data
    fill_rom(1'b0);
    do_load(1, 1'b0, -1, -1);
    finish_load();
    readback();

    // Abort after 10 load cycles
    fill_rom(1'b0);
    do_load(0, 1'b0, 10, -1);
    chk("abort_a_cnt", 32'(bus.a_cnt), 9);
    @(negedge clk);
    chk("abort_idle_rom_en", 32'(bus.rom_en), 0);
    chk("abort_xdone", 32'(bus.xload_done), 0);
    readback();

    // Asynchronous reset mid-load, then a clean full load
    fill_rom(1'b0);
    do_load(2, 1'b0, -1, 15);
    readback();
    fill_rom(1'b0);
    do_load(2, 1'b0, -1, -1);
    finish_load();
    readback();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
